// File: rtl/rtc_bus_responder.sv
// Responder for the multiplexed address/data strobe bus. It holds a bank of
// 2**ADDR_W registers (RTC time/control style), decodes address-write,
// data-write and data-read cycles from the bus master, and returns read data.
// A host port lets local logic (for example a time-tick counter) update registers.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cs_n, rd_n, wr_n      bus chip select and strobes, active low
//   ad_n                  phase select: 0 = address, 1 = data
//   ad_in                 AD bus input
//   ad_out, ad_oe         read data and output enable; the tristate is built at the top level
//   host_we/addr/wdata    single-cycle host register write
//   host_rdata            combinational read of reg[host_addr]
//   addr_q                currently latched bus address
//   wr_pulse              one-cycle pulse on each committed bus data write
//   proto_err             sticky protocol-violation flag (RESP_PROTOCOL_CHECK_EN only)
//
// Build option: define RESP_PROTOCOL_CHECK_EN to add proto_err and its checker.
module rtc_bus_responder #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              ad_n,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] addr_q,
`ifdef RESP_PROTOCOL_CHECK_EN
  output logic              proto_err,
`endif
  output logic              wr_pulse
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StAddrWr, StDataWr, StDataRd} state_e;

  // Input synchronizers: strobes idle high, data idles low.
  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q, ad_sync_q;
  logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
      ad_sync_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      rd_sync_q      <= {rd_sync_q[SYNC_STAGES-2:0], rd_n};
      wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], wr_n};
      ad_sync_q      <= {ad_sync_q[SYNC_STAGES-2:0], ad_n};
      data_sync_q[0] <= ad_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  logic              cs_s, rd_s, wr_s, ad_s;
  logic [DATA_W-1:0] ad_s_data;
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign rd_s      = rd_sync_q[SYNC_STAGES-1];
  assign wr_s      = wr_sync_q[SYNC_STAGES-1];
  assign ad_s      = ad_sync_q[SYNC_STAGES-1];
  assign ad_s_data = data_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] ad_out_d;
  logic              ad_oe_d;
  logic              bus_we;
  logic              wr_exit, rd_exit;
  logic [DATA_W-1:0] regs_q [Depth];

  assign wr_exit    = wr_s | cs_s;
  assign rd_exit    = rd_s | cs_s;
  assign host_rdata = regs_q[host_addr];

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    addr_d   = addr_q;
    ad_out_d = ad_out;
    ad_oe_d  = ad_oe;
    bus_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!cs_s) begin
          if (!rd_s && !wr_s) begin
            // Both strobes low is illegal: ignore.
          end else if (!wr_s) begin
            state_d  = ad_s ? StDataWr : StAddrWr;
            shadow_d = ad_s_data;
          end else if (!rd_s && ad_s) begin
            // Snapshot read data on entry; later register changes do not leak out.
            state_d  = StDataRd;
            ad_out_d = regs_q[addr_q];
            ad_oe_d  = 1'b1;
          end
        end
      end
      StAddrWr: begin
        if (wr_exit) begin
          addr_d  = shadow_q[ADDR_W-1:0];
          state_d = StIdle;
        end else begin
          shadow_d = ad_s_data;
        end
      end
      StDataWr: begin
        if (wr_exit) begin
          bus_we  = 1'b1;
          state_d = StIdle;
        end else begin
          shadow_d = ad_s_data;
        end
      end
      StDataRd: begin
        if (rd_exit) begin
          ad_oe_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      addr_q   <= '0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      wr_pulse <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      addr_q   <= addr_d;
      ad_out   <= ad_out_d;
      ad_oe    <= ad_oe_d;
      wr_pulse <= bus_we;
    end
  end

  // Register bank: a bus commit beats a host write to the same index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else begin
      if (host_we && !(bus_we && (host_addr == addr_q))) regs_q[host_addr] <= host_wdata;
      if (bus_we) regs_q[addr_q] <= shadow_q;
    end
  end

`ifdef RESP_PROTOCOL_CHECK_EN
  logic proto_viol;

  // Phase changes are only flagged while the cycle is still active, so a phase
  // change coincident with strobe release is legal.
  always_comb begin
    proto_viol = (!rd_s && !wr_s) || (cs_s && (!rd_s || !wr_s));
    unique case (state_q)
      StAddrWr: if (!wr_exit && ad_s)  proto_viol = 1'b1;
      StDataWr: if (!wr_exit && !ad_s) proto_viol = 1'b1;
      StDataRd: if (!rd_exit && !ad_s) proto_viol = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) proto_err <= 1'b0;
    else if (proto_viol) proto_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_rtc_bus_responder.sv
`timescale 1ns / 100ps
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cs_n, rd_n, wr_n, ad_n;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic [3:0] addr_q;
  logic       wr_pulse;
`ifdef RESP_PROTOCOL_CHECK_EN
  logic       proto_err;
`endif

  rtc_bus_responder #(
    .DATA_W     (8),
    .ADDR_W     (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cs_n      (cs_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .ad_n      (ad_n),
    .ad_in     (ad_in),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .addr_q    (addr_q),
`ifdef RESP_PROTOCOL_CHECK_EN
    .proto_err (proto_err),
`endif
    .wr_pulse  (wr_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and latched address as seen by the master.
  logic [7:0] mdl [16];
  logic [3:0] maddr;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    maddr = 4'h0;
  endtask

  // One write phase (address or data) with optional host write landing on the commit edge.
  task automatic bus_write(input logic ad_sel, input logic [7:0] data, input int len,
                           input logic coll, input logic [3:0] haddr, input logic [7:0] hdata);
    cs_n  = 1'b0;
    ad_n  = ad_sel;
    ad_in = data;
    tick();
    wr_n = 1'b0;
    repeat (len) tick();
    wr_n = 1'b1;
    tick();
    check_eq("wr_pulse_early", wr_pulse, 0);
    tick();
    if (ad_sel && !coll) begin
      host_addr = maddr;
      #1;
      check_eq("reg_before_commit", host_rdata, mdl[maddr]);
    end
    if (coll) begin
      host_we    = 1'b1;
      host_addr  = haddr;
      host_wdata = hdata;
    end
    tick();
    host_we = 1'b0;
    if (coll && !(ad_sel && haddr == maddr)) mdl[haddr] = hdata;
    if (ad_sel) mdl[maddr] = data;
    else maddr = data[3:0];
    check_eq("wr_pulse_commit", wr_pulse, {31'b0, ad_sel});
    check_eq("addr_q", addr_q, maddr);
    host_addr = maddr;
    #1;
    check_eq("reg_after_commit", host_rdata, mdl[maddr]);
    if (coll) begin
      host_addr = haddr;
      #1;
      check_eq("host_reg_after_commit", host_rdata, mdl[haddr]);
    end
    tick();
    check_eq("wr_pulse_single", wr_pulse, 0);
    cs_n = 1'b1;
    tick();
  endtask

  // Data read; with snap set, the host rewrites the read register mid-read.
  task automatic bus_read(input int len, input logic snap, input logic [7:0] hdata);
    logic [7:0] exp_out;
    exp_out = mdl[maddr];
    cs_n = 1'b0;
    ad_n = 1'b1;
    tick();
    rd_n = 1'b0;
    tick();
    tick();
    check_eq("oe_before_rise", ad_oe, 0);
    tick();
    check_eq("oe_rise", ad_oe, 1);
    check_eq("rd_data", ad_out, exp_out);
    for (int i = 3; i < len; i++) begin
      if (snap && i == 3) begin
        host_we    = 1'b1;
        host_addr  = maddr;
        host_wdata = hdata;
      end
      tick();
      if (snap && i == 3) begin
        host_we = 1'b0;
        mdl[maddr] = hdata;
        #1;
        check_eq("snap_host_rdata", host_rdata, hdata);
      end
      if (snap) check_eq("snap_ad_out", ad_out, exp_out);
    end
    rd_n = 1'b1;
    tick();
    tick();
    check_eq("oe_before_fall", ad_oe, 1);
    tick();
    check_eq("oe_fall", ad_oe, 0);
    check_eq("ad_out_hold", ad_out, exp_out);
    cs_n = 1'b1;
    tick();
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we   = 1'b0;
    mdl[a]    = d;
    #1;
    check_eq("host_write", host_rdata, d);
  endtask

  initial begin
    reset_n    = 1'b0;
    cs_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    ad_n       = 1'b0;
    ad_in      = 8'h00;
    host_we    = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check_eq("rst_ad_oe", ad_oe, 0);
    check_eq("rst_ad_out", ad_out, 0);
    check_eq("rst_addr_q", addr_q, 0);
    check_eq("rst_wr_pulse", wr_pulse, 0);
    host_addr = 4'h9;
    #1;
    check_eq("rst_reg9", host_rdata, 0);
`ifdef RESP_PROTOCOL_CHECK_EN
    check_eq("rst_proto_err", proto_err, 0);
`endif

    // Address 0x05 then data 0xA7, then read it back.
    bus_write(1'b0, 8'h05, 6, 1'b0, 4'h0, 8'h00);
    bus_write(1'b1, 8'hA7, 6, 1'b0, 4'h0, 8'h00);
    bus_write(1'b0, 8'h05, 4, 1'b0, 4'h0, 8'h00);
    bus_read(10, 1'b0, 8'h00);

    // Snapshot: host rewrites reg[3] while it is being read.
    host_write(4'h3, 8'h11);
    bus_write(1'b0, 8'h03, 4, 1'b0, 4'h0, 8'h00);
    bus_read(10, 1'b1, 8'h22);

    // Collision on the same index: bus commit wins.
    bus_write(1'b0, 8'h02, 4, 1'b0, 4'h0, 8'h00);
    bus_write(1'b1, 8'h5A, 4, 1'b1, 4'h2, 8'hFF);

    // Randomized mix, including address bytes with upper bits set.
    for (int it = 0; it < 30; it++) begin
      int unsigned op;
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          bus_write(1'b0, 8'($urandom), int'($urandom_range(3, 8)), 1'b0, 4'h0, 8'h00);
          bus_write(1'b1, 8'($urandom), int'($urandom_range(3, 8)), 1'($urandom),
                    4'($urandom), 8'($urandom));
        end
        1: begin
          bus_write(1'b0, 8'($urandom), int'($urandom_range(3, 8)), 1'b0, 4'h0, 8'h00);
          bus_read(int'($urandom_range(3, 10)), 1'b0, 8'h00);
        end
        2: host_write(4'($urandom), 8'($urandom));
        default: bus_read(int'($urandom_range(3, 10)), 1'($urandom), 8'($urandom));
      endcase
    end

`ifdef RESP_PROTOCOL_CHECK_EN
    // Both strobes low together: flag latches, registers untouched.
    cs_n = 1'b0;
    ad_n = 1'b1;
    rd_n = 1'b0;
    wr_n = 1'b0;
    repeat (5) tick();
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (4) tick();
    cs_n = 1'b1;
    check_eq("proto_err_set", proto_err, 1);
    repeat (4) tick();
    check_eq("proto_err_sticky", proto_err, 1);
    host_addr = maddr;
    #1;
    check_eq("proto_no_reg_change", host_rdata, mdl[maddr]);
`endif

    // Reset in the middle of a read of reg[5].
    bus_write(1'b0, 8'h05, 4, 1'b0, 4'h0, 8'h00);
    bus_write(1'b1, 8'h3C, 4, 1'b0, 4'h0, 8'h00);
    cs_n = 1'b0;
    ad_n = 1'b1;
    tick();
    rd_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_mid_oe_before", ad_oe, 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_mid_oe", ad_oe, 0);
    check_eq("rst_mid_addr_q", addr_q, 0);
    host_addr = 4'h5;
    #1;
    check_eq("rst_mid_reg5", host_rdata, mdl[5]);
    rd_n = 1'b1;
    cs_n = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_oe", ad_oe, 0);
`ifdef RESP_PROTOCOL_CHECK_EN
    check_eq("post_rst_proto_err", proto_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
